// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side prefetch path.
// The buffer depth and level width are fixed together: a 2-entry buffer needs a 0..2 count.
package fifo_pkg;

    localparam int PF_DEPTH = 2;
    localparam int PF_LVL_W = 2;

    typedef logic [PF_LVL_W-1:0] pf_lvl_t;

    function automatic pf_lvl_t pf_bit2lvl(input logic b);
        return pf_lvl_t'(b);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry shift buffer with occupancy count; slot 0 is always the head.
// Writes land at (level - pop) so a simultaneous pop and write keeps order.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr,
    input  logic          pop,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output pf_lvl_t       level
);

    logic [DW-1:0] slot0_q, slot0_d;
    logic [DW-1:0] slot1_q, slot1_d;
    pf_lvl_t       level_q, level_d;
    logic          pop_ok;
    pf_lvl_t       wr_idx;

    assign pop_ok = pop & (level_q != '0);
    assign wr_idx = level_q - pf_bit2lvl(pop_ok);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        level_d = level_q;
        if (clr) begin
            level_d = '0;
        end else begin
            if (pop_ok) begin
                slot0_d = slot1_q;
            end
            // A write placed after the shift wins slot 0 when the buffer drains to it.
            if (wr) begin
                if (wr_idx == '0) begin
                    slot0_d = din;
                end else begin
                    slot1_d = din;
                end
            end
            level_d = level_q + pf_bit2lvl(wr) - pf_bit2lvl(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot0_q <= '0;
            slot1_q <= '0;
            level_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            level_q <= level_d;
        end
    end

    assign dout  = slot0_q;
    assign level = level_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Turns the 1-cycle-latency read port of the upstream FIFO into a valid/ready stream.
// Reads are issued only when the buffer is guaranteed room for the returning word.
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                rclk,
    input  logic                rrstn,
    input  logic                flush,
    input  logic                fifo_empty,
    output logic                fifo_rden,
    input  logic [DW-1:0]       fifo_rd_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DW-1:0]       m_data,
    output logic [PF_LVL_W-1:0] level
);

    logic    inflight_q, inflight_d;
    logic    pop;
    logic    wr;
    logic [2:0] occ;
    pf_lvl_t lvl;

    assign m_valid = (lvl != '0);
    assign pop     = m_valid & m_ready & ~flush;
    assign wr      = inflight_q & ~flush;

    // Occupancy after this cycle's pop plus the word already on its way back.
    assign occ = {1'b0, lvl} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rden  = rrstn & ~flush & ~fifo_empty & (occ <= 3'd1);
    assign inflight_d = fifo_rden;

    always_ff @(posedge rclk) begin
        if (!rrstn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_skid #(
        .DW (DW)
    ) u_skid (
        .clk   (rclk),
        .rstn  (rrstn),
        .wr    (wr),
        .pop   (pop),
        .clr   (flush),
        .din   (fifo_rd_data),
        .dout  (m_data),
        .level (lvl)
    );

    assign level = lvl;

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench: queue-based upstream FIFO and buffer model, directed scenarios then random traffic.
module tb_fifo_rd_prefetch;

    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrstn;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_rden;
    logic [DW-1:0] fifo_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    level;

    always #5 rclk = ~rclk;

    fifo_rd_prefetch #(.DW(DW)) dut (
        .rclk         (rclk),
        .rrstn        (rrstn),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_rden    (fifo_rden),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int maxlvl = 0;

    logic [7:0] up_q[$];
    logic [7:0] buf_q[$];
    bit         infl   = 1'b0;
    logic [7:0] infl_w = '0;
    bit         zero_f = 1'b1;

    logic [7:0] dlv_q[$];
    int         dlv_cyc[$];
    int         rd_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] w);
        up_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        dlv_q.delete();
        dlv_cyc.delete();
        rd_cyc.delete();
    endtask

    // One clock: sample and check against the model, advance model, then act as the upstream FIFO.
    task automatic cycle();
        bit   e_rden, e_pop, rd_s;
        int   occ;
        logic [7:0] w;
        #1;
        e_pop  = rrstn && !flush && m_ready && (buf_q.size() > 0);
        occ    = buf_q.size() + int'(infl) - ((m_ready && !flush && buf_q.size() > 0) ? 1 : 0);
        e_rden = rrstn && !flush && !fifo_empty && (occ <= 1);
        chk("rden",  32'(fifo_rden), 32'(e_rden));
        chk("valid", 32'(m_valid),   32'(buf_q.size() != 0));
        chk("level", 32'(level),     32'(buf_q.size()));
        if (buf_q.size() > 0)
            chk("data", 32'(m_data), 32'(buf_q[0]));
        else if (zero_f)
            chk("data_zero", 32'(m_data), 32'd0);
        if (int'(level) > maxlvl) maxlvl = int'(level);
        assert (!(rrstn && !flush && infl && buf_q.size() == 2 && !e_pop))
            else $error("capture into a full buffer");
        if (rrstn && !flush && m_valid && m_ready) begin
            dlv_q.push_back(m_data);
            dlv_cyc.push_back(cyc);
        end
        rd_s = fifo_rden;
        if (rd_s) rd_cyc.push_back(cyc);

        if (!rrstn) begin
            buf_q.delete();
            infl   = 1'b0;
            zero_f = 1'b1;
        end else if (flush) begin
            buf_q.delete();
            infl = 1'b0;
        end else begin
            if (e_pop) void'(buf_q.pop_front());
            if (infl) begin
                buf_q.push_back(infl_w);
                zero_f = 1'b0;
            end
            infl = e_rden;
        end

        @(posedge rclk);
        #1;
        if (rd_s && up_q.size() > 0) begin
            w            = up_q.pop_front();
            fifo_rd_data = w;
            infl_w       = w;
        end else begin
            fifo_rd_data = 8'($urandom);
        end
        fifo_empty = (up_q.size() == 0);
        @(negedge rclk);
        cyc++;
    endtask

    initial begin
        int c0;
        logic [7:0] nextw;
        rrstn        = 1'b0;
        flush        = 1'b0;
        m_ready      = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        repeat (2) @(posedge rclk);
        @(negedge rclk);

        // Reset held with a non-empty FIFO.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        m_ready = 1'b1;
        repeat (3) cycle();

        // Back-to-back stream after reset release.
        rrstn = 1'b1;
        c0 = cyc;
        clear_logs();
        repeat (8) cycle();
        chk("s2_nrd", 32'(rd_cyc.size()), 32'd4);
        for (int i = 0; i < rd_cyc.size() && i < 4; i++)
            chk("s2_rd_cyc", 32'(rd_cyc[i]), 32'(c0 + i));
        chk("s2_nbeat", 32'(dlv_q.size()), 32'd4);
        for (int i = 0; i < dlv_q.size() && i < 4; i++) begin
            chk("s2_beat",     32'(dlv_q[i]),   32'(8'h11 * (i + 1)));
            chk("s2_beat_cyc", 32'(dlv_cyc[i]), 32'(c0 + 2 + i));
        end

        // Backpressure: buffer fills to two, head held, then drains gap-free.
        m_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 5; i++) push(8'(8'h51 + i));
        repeat (6) cycle();
        chk("s3_nrd",   32'(rd_cyc.size()), 32'd2);
        chk("s3_level", 32'(level),  32'd2);
        chk("s3_head",  32'(m_data), 32'h51);
        m_ready = 1'b1;
        c0 = cyc;
        clear_logs();
        repeat (8) cycle();
        chk("s3_nbeat", 32'(dlv_q.size()), 32'd5);
        for (int i = 0; i < dlv_q.size() && i < 5; i++) begin
            chk("s3_beat",     32'(dlv_q[i]),   32'(8'h51 + i));
            chk("s3_beat_cyc", 32'(dlv_cyc[i]), 32'(c0 + i));
        end

        // Alternating ready.
        clear_logs();
        maxlvl = 0;
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        for (int k = 0; k < 40; k++) begin
            m_ready = (k % 2 == 0);
            cycle();
        end
        chk("s4_nbeat", 32'(dlv_q.size()), 32'd8);
        for (int i = 0; i < dlv_q.size() && i < 8; i++)
            chk("s4_beat", 32'(dlv_q[i]), 32'(8'hA0 + i));
        chk("s4_lvl_le2", 32'(maxlvl <= 2), 32'd1);

        // Flush with a full buffer.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'hB0 + i));
        repeat (4) cycle();
        chk("s5_full", 32'(level), 32'd2);
        nextw = up_q[0];
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("s5_level", 32'(level),   32'd0);
        chk("s5_valid", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        clear_logs();
        repeat (10) cycle();
        chk("s5_next", (dlv_q.size() > 0) ? 32'(dlv_q[0]) : 32'hFFFF, 32'(nextw));

        // Flush while a word is in flight (full buffer and in-flight cannot coexist).
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'hD0 + i));
        repeat (2) cycle();
        nextw = up_q[0];
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("s5b_level", 32'(level),   32'd0);
        chk("s5b_valid", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        clear_logs();
        repeat (6) cycle();
        chk("s5b_next", (dlv_q.size() > 0) ? 32'(dlv_q[0]) : 32'hFFFF, 32'(nextw));

        // One-cycle reset pulse mid-stream.
        for (int i = 0; i < 8; i++) push(8'(8'hE0 + i));
        repeat (4) cycle();
        rrstn = 1'b0;
        #1;
        chk("s6_rden", 32'(fifo_rden), 32'd0);
        cycle();
        rrstn = 1'b1;
        chk("s6_level", 32'(level),   32'd0);
        chk("s6_valid", 32'(m_valid), 32'd0);
        chk("s6_data",  32'(m_data),  32'd0);
        repeat (15) cycle();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            m_ready = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 15) == 0);
            rrstn   = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rrstn = 1'b1;
        flush = 1'b0;
        m_ready = 1'b1;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
